// File: rtl/axis_master_tx.sv
// ----------------------------------------------------------------------------
// axis_master_tx : FIFO-buffered AXI-Stream master that releases whole packets
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axis_master_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        wr_last,
  output logic                        full_out,
  output logic                        empty_out,
  output logic [$clog2(FIFO_DEPTH):0] count_out,
  output logic                        drop_out,
  output logic                        tvalid_out,
  output logic [DATA_WIDTH-1:0]       tdata_out,
  output logic                        tlast_out,
  input  logic                        tready_in,
  output logic                        pkt_done_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       pkt_cnt;
  logic                drop;
  logic                pkt_done;

  logic                push;
  logic                pop;
  logic                pop_last;
  logic [DATA_WIDTH:0] head;

  assign full_out     = (count == DEPTH_C);
  assign empty_out    = (count == '0);
  assign count_out    = count;
  assign drop_out     = drop;
  assign pkt_done_out = pkt_done;

  assign head     = mem[rd_ptr];
  assign push     = wr_en & ~full_out;
  assign pop      = (state == STREAM) & tready_in;
  assign pop_last = pop & head[DATA_WIDTH];

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {wr_last, wr_data};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pkt_cnt  <= '0;
      drop     <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({push & wr_last, pop_last})
        2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
      drop     <= wr_en & full_out;
      pkt_done <= pop_last;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A complete packet in the buffer guarantees the head word exists for the
  // whole STREAM phase, so the head never under-runs mid-packet.
  always_comb begin
    state_nxt  = state;
    tvalid_out = 1'b0;
    tdata_out  = '0;
    tlast_out  = 1'b0;
    case (state)
      IDLE: begin
        if (pkt_cnt != '0) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        tvalid_out = 1'b1;
        tdata_out  = head[DATA_WIDTH-1:0];
        tlast_out  = head[DATA_WIDTH];
        if (pop_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_master_tx.sv
// ----------------------------------------------------------------------------
// tb_axis_master_tx : directed bench with a queue-based packet model
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axis_master_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          aclk    = 1'b0;
  logic          areset  = 1'b1;
  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_last = 1'b0;
  logic          tready_in = 1'b0;
  logic          full_out, empty_out, drop_out, tvalid_out, tlast_out, pkt_done_out;
  logic [3:0]    count_out;
  logic [DW-1:0] tdata_out;

  always #5 aclk = ~aclk;

  axis_master_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .full_out(full_out), .empty_out(empty_out), .count_out(count_out),
    .drop_out(drop_out), .tvalid_out(tvalid_out), .tdata_out(tdata_out),
    .tlast_out(tlast_out), .tready_in(tready_in), .pkt_done_out(pkt_done_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: buffer as a queue of {last,data}; valid rises one edge after a whole
  // packet is buffered and drops on the edge that hands over the last beat.
  logic [DW:0] mq [$];
  logic [DW:0] beats [$];
  logic [DW:0] exp_head;
  bit m_valid, m_drop, m_done;
  bit mdl_pop, mdl_pop_last, mdl_full;
  int mdl_pkts;
  int done_cnt = 0;
  bit seen_valid = 0;

  always @(negedge aclk) begin
    if (areset) begin
      mq.delete();
      m_valid = 0; m_drop = 0; m_done = 0;
    end
    exp_head = '0;
    if (m_valid && mq.size() > 0) exp_head = mq[0];
    check("tvalid", tvalid_out, m_valid);
    check("tdata", tdata_out, exp_head[DW-1:0]);
    check("tlast", tlast_out, exp_head[DW]);
    check("count", count_out, mq.size());
    check("full", full_out, mq.size() == DEPTH);
    check("empty", empty_out, mq.size() == 0);
    check("drop", drop_out, m_drop);
    check("pkt_done", pkt_done_out, m_done);
    if (pkt_done_out) done_cnt++;
    if (tvalid_out) seen_valid = 1;
    if (!areset) begin
      if (tvalid_out && tready_in) beats.push_back({tlast_out, tdata_out});
      mdl_pop      = m_valid && tready_in;
      mdl_pop_last = mdl_pop && exp_head[DW];
      mdl_full     = (mq.size() == DEPTH);
      mdl_pkts     = 0;
      foreach (mq[i]) if (mq[i][DW]) mdl_pkts++;
      m_drop = wr_en && mdl_full;
      m_done = mdl_pop_last;
      if (m_valid) m_valid = !mdl_pop_last;
      else         m_valid = (mdl_pkts > 0);
      if (mdl_pop) void'(mq.pop_front());
      if (wr_en && !mdl_full) mq.push_back({wr_last, wr_data});
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic write(input logic [DW-1:0] d, input logic l);
    wr_en = 1'b1; wr_data = d; wr_last = l;
    step();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!tvalid_out && k < budget) begin step(); k++; end
    check(name, tvalid_out, 1'b1);
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int k = 0;
    while (beats.size() < n && k < budget) begin step(); k++; end
    check(name, beats.size() >= n, 1'b1);
  endtask

  logic [6:0] pat;
  logic [5:0] vseq;

  initial begin
    repeat (2) step();
    check("rst_tvalid", tvalid_out, 1'b0);
    check("rst_empty", empty_out, 1'b1);
    check("rst_count", count_out, 4'd0);
    check("rst_full", full_out, 1'b0);
    areset = 1'b0;
    step();

    // Basic 3-word packet
    tready_in = 1'b1; beats.delete(); done_cnt = 0;
    write(32'hA1, 1'b0); write(32'hA2, 1'b0); write(32'hA3, 1'b1);
    wait_beats("s1_timeout", 3, 50);
    repeat (3) step();
    check("s1_nbeats", beats.size(), 3);
    check("s1_beat0", beats[0], {1'b0, 32'hA1});
    check("s1_beat1", beats[1], {1'b0, 32'hA2});
    check("s1_beat2", beats[2], {1'b1, 32'hA3});
    check("s1_done", done_cnt, 1);
    check("s1_empty", empty_out, 1'b1);

    // Incomplete packet is held back until its last word arrives
    beats.delete(); seen_valid = 0;
    write(32'hB1, 1'b0); write(32'hB2, 1'b0);
    repeat (10) step();
    check("s2_no_valid", seen_valid, 1'b0);
    check("s2_count", count_out, 4'd2);
    write(32'hB3, 1'b1);
    wait_beats("s2_timeout", 3, 50);
    check("s2_beat0", beats[0], {1'b0, 32'hB1});
    check("s2_beat2", beats[2], {1'b1, 32'hB3});
    repeat (3) step();

    // Back-pressure pattern 1,0,0,1,0,1,1
    tready_in = 1'b0; beats.delete();
    for (int i = 0; i < 4; i++) write(32'hC0 + i, i == 3);
    wait_valid("s3_timeout", 20);
    pat = 7'b1101001;
    for (int i = 0; i < 7; i++) begin tready_in = pat[i]; step(); end
    tready_in = 1'b0;
    repeat (3) step();
    check("s3_nbeats", beats.size(), 4);
    for (int i = 0; i < 4; i++) check("s3_order", beats[i], {i == 3, 32'hC0 + i});
    check("s3_empty", empty_out, 1'b1);

    // Overflow: ninth write dropped
    beats.delete();
    for (int i = 0; i < 8; i++) write(32'hD0 + i, i == 7);
    check("s4_full", full_out, 1'b1);
    check("s4_count8", count_out, 4'd8);
    write(32'hEE, 1'b0);
    check("s4_drop", drop_out, 1'b1);
    check("s4_count_after_drop", count_out, 4'd8);
    step();
    check("s4_drop_clear", drop_out, 1'b0);
    tready_in = 1'b1;
    wait_beats("s4_timeout", 8, 50);
    check("s4_first", beats[0], {1'b0, 32'hD0});
    check("s4_last", beats[7], {1'b1, 32'hD7});
    repeat (3) step();

    // Two buffered 2-word packets: exactly one idle cycle between them
    tready_in = 1'b0; beats.delete(); done_cnt = 0;
    write(32'hE0, 1'b0); write(32'hE1, 1'b1); write(32'hE2, 1'b0); write(32'hE3, 1'b1);
    wait_valid("s5_timeout", 20);
    tready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin vseq[i] = tvalid_out; step(); end
    check("s5_valid_seq", vseq, 6'b011011);
    repeat (2) step();
    check("s5_done", done_cnt, 2);
    check("s5_nbeats", beats.size(), 4);

    // 20 packets to exercise pointer wrap
    beats.delete(); done_cnt = 0;
    for (int p = 0; p < 20; p++) begin
      write(32'h100 + 2 * p, 1'b0); write(32'h101 + 2 * p, 1'b1); step();
    end
    wait_beats("s5b_timeout", 40, 100);
    repeat (3) step();
    check("s5b_done", done_cnt, 20);
    for (int i = 0; i < 40; i++) check("s5b_beat", beats[i], {i[0], 32'h100 + i});

    // Reset in the middle of a 5-beat packet
    tready_in = 1'b0; beats.delete(); done_cnt = 0;
    for (int i = 0; i < 5; i++) write(32'h60 + i, i == 4);
    wait_valid("s6_timeout", 20);
    tready_in = 1'b1;
    step(); step();
    #1 areset = 1'b1;
    #1;
    check("s6_nbeats", beats.size(), 2);
    check("s6_rst_tvalid", tvalid_out, 1'b0);
    check("s6_rst_tdata", tdata_out, 32'h0);
    check("s6_rst_tlast", tlast_out, 1'b0);
    check("s6_rst_count", count_out, 4'd0);
    check("s6_rst_empty", empty_out, 1'b1);
    check("s6_rst_done", pkt_done_out, 1'b0);
    tready_in = 1'b0;
    repeat (2) step();
    areset = 1'b0;
    step();
    check("s6_no_done", done_cnt, 0);
    tready_in = 1'b1; beats.delete();
    write(32'h55, 1'b1);
    wait_beats("s6b_timeout", 1, 20);
    repeat (3) step();
    check("s6_beat", beats[0], {1'b1, 32'h55});
    check("s6_done", done_cnt, 1);
    check("s6_empty", empty_out, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
